// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 types and constants for the host transmitter and scancode receiver
//
// Contents:
//   ps2_tx_state_t  host-to-device transmitter state encoding
//   CMD_*           common keyboard command bytes
//   RSP_*           common keyboard response bytes
//   build_frame()   10-bit payload {stop, odd parity, data} shifted out LSB first
package ps2_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_INHIBIT   = 4'd1,
        ST_REQ       = 4'd2,
        ST_WAIT_CLK  = 4'd3,
        ST_SHIFT     = 4'd4,
        ST_ACK       = 4'd5,
        ST_WAIT_IDLE = 4'd6,
        ST_DONE      = 4'd7,
        ST_ERR       = 4'd8
    } ps2_tx_state_t;

    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ECHO     = 8'hEE;

    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_RESEND   = 8'hFE;

    // Parity bit makes the total count of ones across data+parity odd.
    function automatic logic [9:0] build_frame(input logic [7:0] data);
        return {1'b1, ~^data, data};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - synchronizer, glitch filter and falling-edge strobe for one PS/2 line
//
// Ports:
//   iCLK_50   system clock
//   iRST_n    asynchronous active-low reset (filtered level resets to idle-high)
//   line_in   raw asynchronous line level
//   level     filtered line level
//   fall      one-cycle strobe on a filtered 1->0 transition
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic iCLK_50,
    input  logic iRST_n,
    input  logic line_in,
    output logic level,
    output logic fall
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // The filtered level only moves after FILTER_LEN consecutive synchronized
    // samples disagree with it; any agreeing sample restarts the run.
    always_ff @(posedge iCLK_50 or negedge iRST_n) begin
        if (!iRST_n) begin
            sync  <= 2'b11;
            cnt   <= '0;
            level <= 1'b1;
            fall  <= 1'b0;
        end else begin
            sync <= {sync[0], line_in};
            fall <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_LEN - 1)) begin
                level <= sync[1];
                cnt   <= '0;
                // level differs from the sample, so level=1 means 1->0
                fall  <= level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter with open-drain line control
//
// Ports:
//   iCLK_50, iRST_n          system clock, asynchronous active-low reset
//   tx_data/tx_valid/tx_ready command byte handshake (accepted only in IDLE)
//   tx_busy                  high from accept until return to IDLE
//   tx_done / tx_error       one-cycle completion pulses (ACK / NACK or timeout)
//   ps2_clk_in, ps2_dat_in   raw PS2_CLK / PS2_DAT levels
//   ps2_clk_oe, ps2_dat_oe   1 pulls the line low, 0 releases it
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_HZ         = 50_000_000,
    parameter int INHIBIT_CYCLES = 6000,
    parameter int START_TIMEOUT  = 750_000,
    parameter int FRAME_TIMEOUT  = 100_000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       iCLK_50,
    input  logic       iRST_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    // Never hold the clock low for less than 100 us, whatever INHIBIT_CYCLES says.
    localparam int MIN_INHIBIT = CLK_HZ / 10_000;
    localparam int INH_LEN     = (INHIBIT_CYCLES > MIN_INHIBIT) ? INHIBIT_CYCLES : MIN_INHIBIT;
    localparam int TMAX_A      = (START_TIMEOUT > FRAME_TIMEOUT) ? START_TIMEOUT : FRAME_TIMEOUT;
    localparam int TMAX        = (TMAX_A > INH_LEN) ? TMAX_A : INH_LEN;
    localparam int TW          = $clog2(TMAX + 1);

    ps2_tx_state_t state, state_n;
    logic [TW-1:0] tmr, tmr_n, tmr_inc;
    logic [3:0]    bit_cnt, bit_n;
    logic [9:0]    frame, frame_n;
    logic          clk_oe_q, clk_oe_n;
    logic          dat_oe_q, dat_oe_n;

    logic clk_level, clk_fall;
    logic dat_level, dat_fall;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .iCLK_50 (iCLK_50),
        .iRST_n  (iRST_n),
        .line_in (ps2_clk_in),
        .level   (clk_level),
        .fall    (clk_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filter (
        .iCLK_50 (iCLK_50),
        .iRST_n  (iRST_n),
        .line_in (ps2_dat_in),
        .level   (dat_level),
        .fall    (dat_fall)
    );

    // Saturating so a stuck state can never wrap back under its timeout.
    assign tmr_inc = (tmr == '1) ? tmr : tmr + 1'b1;

    always_ff @(posedge iCLK_50 or negedge iRST_n) begin
        if (!iRST_n) begin
            state    <= ST_IDLE;
            tmr      <= '0;
            bit_cnt  <= '0;
            frame    <= '0;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
        end else begin
            state    <= state_n;
            tmr      <= tmr_n;
            bit_cnt  <= bit_n;
            frame    <= frame_n;
            clk_oe_q <= clk_oe_n;
            dat_oe_q <= dat_oe_n;
        end
    end

    always_comb begin
        state_n  = state;
        tmr_n    = tmr;
        bit_n    = bit_cnt;
        frame_n  = frame;
        dat_oe_n = dat_oe_q;
        clk_oe_n = 1'b0;

        case (state)
            ST_IDLE: begin
                if (tx_valid) begin
                    frame_n = build_frame(tx_data);
                    tmr_n   = '0;
                    state_n = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                tmr_n = tmr_inc;
                if (tmr == TW'(INH_LEN - 1)) begin
                    state_n  = ST_REQ;
                    dat_oe_n = 1'b1;    // start bit goes out while clock is still held
                end
            end
            ST_REQ: begin
                tmr_n   = '0;
                state_n = ST_WAIT_CLK;
            end
            ST_WAIT_CLK: begin
                tmr_n = tmr_inc;
                if (clk_fall) begin
                    // Fall 1: present data bit 0; frame timer starts here.
                    dat_oe_n = ~frame[0];
                    bit_n    = 4'd1;
                    tmr_n    = '0;
                    state_n  = ST_SHIFT;
                end else if (tmr == TW'(START_TIMEOUT)) begin
                    state_n = ST_ERR;
                end
            end
            ST_SHIFT: begin
                tmr_n = tmr_inc;
                if (tmr == TW'(FRAME_TIMEOUT)) begin
                    state_n = ST_ERR;
                end else if (clk_fall) begin
                    // Falls 2..10 present frame[1..9]; frame[9] is the released stop bit.
                    dat_oe_n = ~frame[bit_cnt];
                    bit_n    = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd9) begin
                        state_n = ST_ACK;
                    end
                end
            end
            ST_ACK: begin
                tmr_n = tmr_inc;
                if (tmr == TW'(FRAME_TIMEOUT)) begin
                    state_n = ST_ERR;
                end else if (clk_fall) begin
                    state_n = dat_level ? ST_ERR : ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                tmr_n = tmr_inc;
                if (tmr == TW'(FRAME_TIMEOUT)) begin
                    state_n = ST_ERR;
                end else if (clk_level && dat_level) begin
                    state_n = ST_DONE;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            ST_ERR:  state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase

        // Line drives are registered from the next state so ERR releases
        // both lines in the same cycle it is entered.
        clk_oe_n = (state_n == ST_INHIBIT) || (state_n == ST_REQ);
        if ((state_n == ST_IDLE) || (state_n == ST_DONE) || (state_n == ST_ERR) ||
            (state_n == ST_INHIBIT)) begin
            dat_oe_n = 1'b0;
        end
    end

    assign tx_ready   = (state == ST_IDLE);
    assign tx_busy    = (state != ST_IDLE);
    assign tx_done    = (state == ST_DONE);
    assign tx_error   = (state == ST_ERR);
    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;

    // Only the clock line's edges matter to the transmitter.
    logic unused_dat_fall;
    assign unused_dat_fall = dat_fall;

endmodule
